traffic_cfg_master: RTL

Command-issuing end of the traffic-light configuration bus. Holds a per-light configuration table loaded from board switches, then on a go request serially programs every light: red time, then green time, then one global `inst_go` strobe. It drives the shared `inst_send`/`inst_go`/`traffic_sel`/`color_sel`/`start_color`/`input_time` bus that all traffic-light instances sample. Sits between the debounced button/switch front end and the traffic-light array.

---
 rtl/traffic_pkg.sv | 13 +
 rtl/traffic_cfg_master_if.sv | 11 +
 rtl/traffic_cfg_table.sv | 35 +++
 rtl/traffic_cfg_master.sv | 102 ++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and constants for the traffic-light configuration bus
package traffic_pkg;
    localparam int TIME_W = 4;
    localparam logic [TIME_W-1:0] DEFAULT_TIME = 4'd10;
    localparam logic PH_RED = 1'b0;
    localparam logic PH_GREEN = 1'b1;
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GO} state_t;
    typedef struct packed {
        logic [TIME_W-1:0] red;
        logic [TIME_W-1:0] green;
        logic              start_c;
    } cfg_entry_t;
endpackage

// File: rtl/traffic_cfg_master_if.sv
// traffic_cfg_master_if: shared command bus sampled by every traffic-light instance
interface traffic_cfg_master_if;
    logic                             inst_send;
    logic                             inst_go;
    logic [1:0]                       traffic_sel;
    logic                             color_sel;
    logic                             start_color;
    logic [traffic_pkg::TIME_W-1:0]   input_time;
    modport master (output inst_send, inst_go, traffic_sel, color_sel, start_color, input_time);
    modport slave  (input  inst_send, inst_go, traffic_sel, color_sel, start_color, input_time);
endinterface

// File: rtl/traffic_cfg_table.sv
// traffic_cfg_table: per-light red/green/start-color register file, one write port, one read port
module traffic_cfg_table
    import traffic_pkg::*;
#(
    parameter int NUM_LIGHTS = 4,
    parameter logic [TIME_W-1:0] DEFAULT_TIME = traffic_pkg::DEFAULT_TIME
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        wr_idx,
    input  logic              wr_green,
    input  logic [TIME_W-1:0] wr_time,
    input  logic              wr_start,
    input  logic [1:0]        rd_idx,
    output cfg_entry_t        rd_entry
);
    cfg_entry_t tbl [NUM_LIGHTS];
    logic in_range;
    logic [TIME_W-1:0] wr_val;
    assign in_range = {1'b0, wr_idx} < 3'(NUM_LIGHTS);
    // a zero time would never expire in the light, so it is stored as one
    assign wr_val = (wr_time == '0) ? TIME_W'(1) : wr_time;
    assign rd_entry = tbl[rd_idx];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_LIGHTS; k++)
                tbl[k] <= '{red: DEFAULT_TIME, green: DEFAULT_TIME, start_c: 1'b0};
        end else if (we && in_range) begin
            if (wr_green) tbl[wr_idx].green <= wr_val;
            else          tbl[wr_idx].red   <= wr_val;
            tbl[wr_idx].start_c <= wr_start;
        end
    end
endmodule

// File: rtl/traffic_cfg_master.sv
// traffic_cfg_master: programs red/green times into every light over the shared bus, then strobes go
module traffic_cfg_master
    import traffic_pkg::*;
#(
    parameter int NUM_LIGHTS = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter logic [TIME_W-1:0] DEFAULT_TIME = traffic_pkg::DEFAULT_TIME
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn_load,
    input  logic                         btn_go,
    input  logic [1:0]                   sw_light,
    input  logic                         sw_color,
    input  logic                         sw_start_color,
    input  logic [TIME_W-1:0]            sw_time,
    traffic_cfg_master_if.master         bus,
    output logic                         busy,
    output logic                         running
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    state_t state, nxt;
    logic [1:0] light, nxt_light;
    logic phase, nxt_phase;
    logic [CW-1:0] cnt, nxt_cnt;
    cfg_entry_t rd_entry;
    traffic_cfg_table #(.NUM_LIGHTS(NUM_LIGHTS), .DEFAULT_TIME(DEFAULT_TIME)) u_table (
        .clk      (clk),
        .rst      (rst),
        .we       (btn_load && state == IDLE),
        .wr_idx   (sw_light),
        .wr_green (sw_color),
        .wr_time  (sw_time),
        .wr_start (sw_start_color),
        .rd_idx   (nxt_light),
        .rd_entry (rd_entry)
    );
    always_comb begin
        nxt = state;
        nxt_light = light;
        nxt_phase = phase;
        nxt_cnt = cnt;
        case (state)
            IDLE: begin
                // a load in the same cycle wins and the go request is dropped
                if (btn_go && !btn_load) begin
                    nxt = running ? GO : SETUP;
                    nxt_light = running ? light : 2'd0;
                    nxt_phase = running ? phase : PH_RED;
                end
            end
            SETUP: nxt = STROBE;
            STROBE: begin
                nxt = HOLD;
                nxt_cnt = '0;
            end
            HOLD: begin
                if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    nxt = (phase == PH_GREEN && light == 2'(NUM_LIGHTS - 1)) ? GO : SETUP;
                    nxt_phase = (phase == PH_RED) ? PH_GREEN : PH_RED;
                    nxt_light = (phase == PH_GREEN && nxt == SETUP) ? light + 2'd1 : light;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            GO: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            light <= '0;
            phase <= PH_RED;
            cnt <= '0;
            bus.inst_send <= 1'b0;
            bus.inst_go <= 1'b0;
            bus.traffic_sel <= '0;
            bus.color_sel <= 1'b0;
            bus.start_color <= 1'b0;
            bus.input_time <= '0;
            busy <= 1'b0;
            running <= 1'b0;
        end else begin
            state <= nxt;
            light <= nxt_light;
            phase <= nxt_phase;
            cnt <= nxt_cnt;
            bus.inst_send <= (nxt == STROBE);
            bus.inst_go <= (nxt == GO);
            busy <= (nxt != IDLE);
            if (nxt == GO) running <= !running;
            // fields latch on entry to SETUP and hold through STROBE/HOLD and IDLE
            if (nxt == SETUP) begin
                bus.traffic_sel <= nxt_light;
                bus.color_sel <= nxt_phase;
                bus.input_time <= (nxt_phase == PH_GREEN) ? rd_entry.green : rd_entry.red;
                bus.start_color <= rd_entry.start_c;
            end
        end
    end
endmodule
